// File: rtl/devil_pkg.sv
// Shared encodings for the devil path arbiter: FSM states, owner codes,
// control/status bit positions and the control-word decode.
package devil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_RELEASE = 3'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'b00,
    OWN_PASSIVE = 2'b01,
    OWN_ACTIVE  = 2'b10
  } owner_t;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_FIXED_ACT  = 1;
  localparam int CTRL_RR_EN      = 2;
  localparam int CTRL_CNT_CLR    = 3;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_LAST_ACT   = 1;
  localparam int STAT_WDT        = 2;
  localparam int STAT_CNT_LSB    = 16;

  typedef struct packed {
    logic cnt_clr;
    logic rr_en;
    logic fixed_active;
    logic enable;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [3:0] bits);
    ctrl_t c;
    c.enable       = bits[CTRL_EN];
    c.fixed_active = bits[CTRL_FIXED_ACT];
    c.rr_en        = bits[CTRL_RR_EN];
    c.cnt_clr      = bits[CTRL_CNT_CLR];
    return c;
  endfunction

endpackage

// File: rtl/devil_rr_picker.sv
// Combinational winner select between the passive and active paths.
// Contention resolves by round-robin (opposite of last owner) or a fixed pick.
module devil_rr_picker
  import devil_pkg::*;
(
  input  logic   req_passive,
  input  logic   req_active,
  input  logic   last_active,
  input  ctrl_t  ctrl,
  output owner_t winner
);

  always_comb begin
    winner = OWN_NONE;
    if (req_passive && req_active) begin
      if (ctrl.rr_en) winner = last_active ? OWN_PASSIVE : OWN_ACTIVE;
      else            winner = ctrl.fixed_active ? OWN_ACTIVE : OWN_PASSIVE;
    end else if (req_passive) begin
      winner = OWN_PASSIVE;
    end else if (req_active) begin
      winner = OWN_ACTIVE;
    end
  end

endmodule

// File: rtl/devil_path_arbiter.sv
// Two-path snoop arbiter: IDLE -> LAUNCH -> RUN -> RELEASE with grant counter.
// Optional RUN-state watchdog compiled in with DEVIL_ARB_WATCHDOG_EN.
module devil_path_arbiter
  import devil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int WDT_CYCLES         = 4096
) (
  input  logic                          ace_aclk,
  input  logic                          ace_aresetn,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
  input  logic                          i_req_passive,
  input  logic                          i_req_active,
  input  logic                          i_end_passive,
  input  logic                          i_end_active,
  input  logic                          i_busy_passive,
  input  logic                          i_busy_active,
  output logic                          o_trigger_passive_path,
  output logic                          o_trigger_active_path,
  output logic [1:0]                    o_owner,
  output logic [2:0]                    o_arb_state,
  output logic [15:0]                   o_grant_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_status_reg
);

  if (WDT_CYCLES < 2 || WDT_CYCLES > 65535 || C_S_AXI_DATA_WIDTH < 32) begin : g_param_check
    $error("devil_path_arbiter: parameter out of legal range");
  end

  ctrl_t      ctrl;
  arb_state_t state, state_nxt;
  owner_t     owner, winner;
  logic       last_active;
  logic       launch_ok;
  logic       owner_end;
  logic       wdt_expire;
  logic       wdt_fired;
  logic [15:0] grant_count;
  logic [C_S_AXI_DATA_WIDTH-1:0] status_nxt;
  logic       unused_ctrl_hi;

  assign ctrl           = decode_ctrl(i_control_reg[3:0]);
  assign unused_ctrl_hi = ^i_control_reg[C_S_AXI_DATA_WIDTH-1:4];

  devil_rr_picker u_picker (
    .req_passive (i_req_passive),
    .req_active  (i_req_active),
    .last_active (last_active),
    .ctrl        (ctrl),
    .winner      (winner)
  );

  assign launch_ok = ctrl.enable && (i_req_passive || i_req_active) &&
                     !i_busy_passive && !i_busy_active;
  // Only the owning engine may close a grant.
  assign owner_end = (owner == OWN_PASSIVE && i_end_passive) ||
                     (owner == OWN_ACTIVE  && i_end_active);

`ifdef DEVIL_ARB_WATCHDOG_EN
  localparam logic [15:0] WDT_LIMIT = 16'(WDT_CYCLES - 1);
  logic [15:0] wdt_cnt;

  // Held at zero outside RUN, so every RUN entry starts a fresh count.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn)         wdt_cnt <= '0;
    else if (state != ST_RUN) wdt_cnt <= '0;
    else                      wdt_cnt <= wdt_cnt + 16'd1;
  end

  assign wdt_expire = (state == ST_RUN) && !owner_end && (wdt_cnt == WDT_LIMIT);

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn)    wdt_fired <= 1'b0;
    else if (wdt_expire) wdt_fired <= 1'b1;
  end
`else
  assign wdt_expire = 1'b0;
  assign wdt_fired  = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (launch_ok) state_nxt = ST_LAUNCH;
      ST_LAUNCH:  state_nxt = ST_RUN;
      ST_RUN:     if (owner_end || wdt_expire) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs; owner is one-hot so the triggers are exclusive
  always_comb begin
    o_trigger_passive_path = 1'b0;
    o_trigger_active_path  = 1'b0;
    if (state == ST_LAUNCH) begin
      o_trigger_passive_path = (owner == OWN_PASSIVE);
      o_trigger_active_path  = (owner == OWN_ACTIVE);
    end
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      owner       <= OWN_NONE;
      last_active <= 1'b1;
    end else if (state == ST_IDLE && launch_ok) begin
      owner       <= winner;
    end else if (state == ST_RELEASE) begin
      owner       <= OWN_NONE;
      last_active <= (owner == OWN_ACTIVE);
    end
  end

  // Clear is a level and wins over a coincident LAUNCH increment.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn)             grant_count <= '0;
    else if (ctrl.cnt_clr)        grant_count <= '0;
    else if (state == ST_LAUNCH)  grant_count <= grant_count + 16'd1;
  end

  always_comb begin
    status_nxt                         = '0;
    status_nxt[STAT_BUSY]              = (state != ST_IDLE);
    status_nxt[STAT_LAST_ACT]          = last_active;
    status_nxt[STAT_WDT]               = wdt_fired;
    status_nxt[STAT_CNT_LSB +: 16]     = grant_count;
  end

  // Registered so the word reads all-zero while reset is held.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) o_status_reg <= '0;
    else              o_status_reg <= status_nxt;
  end

  assign o_owner       = owner;
  assign o_arb_state   = state;
  assign o_grant_count = grant_count;

endmodule

// File: doc/devil_path_arbiter.md
DEVIL_PATH_ARBITER -- requirements
Module: devil_path_arbiter

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, width of the control and status register words.
REQ-002 SHALL have parameter WDT_CYCLES, default 4096, watchdog limit in ace_aclk cycles; legal range 2..65535.
REQ-003 SHALL have port ace_aclk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port ace_aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_control_reg, input, C_S_AXI_DATA_WIDTH, with bit0 = arbiter enable, bit1 = fixed-priority winner (0 passive, 1 active), bit2 = round-robin enable, bit3 = cycle-stable clear of o_grant_count.
REQ-006 SHALL have ports i_req_passive and i_req_active, input, 1 each, level requests from the snoop-match logic.
REQ-007 SHALL have ports i_end_passive and i_end_active, input, 1 each, one-cycle completion pulses from the passive and active engines.
REQ-008 SHALL have ports i_busy_passive and i_busy_active, input, 1 each, engine busy levels.
REQ-009 SHALL have ports o_trigger_passive_path and o_trigger_active_path, output, 1 each, one-cycle launch pulses to the engines.
REQ-010 SHALL have port o_owner, output, 2, with encoding 00 none, 01 passive, 10 active.
REQ-011 SHALL have port o_arb_state, output, 3, the current FSM state encoding.
REQ-012 SHALL have port o_grant_count, output, 16, total grants issued.
REQ-013 SHALL have port o_status_reg, output, C_S_AXI_DATA_WIDTH, with bit0 = busy, bit1 = last owner active, bit2 = watchdog fired (sticky), bits[31:16] = o_grant_count, others 0.

Function
REQ-014 SHALL implement FSM states IDLE=0, LAUNCH=1, RUN=2, RELEASE=3.
REQ-015 SHALL, in IDLE with enable=1 and at least one request and both engines not busy, pick a winner, register o_owner and move to LAUNCH; otherwise it SHALL remain in IDLE.
REQ-016 SHALL grant a single request directly to its requester.
REQ-017 SHALL, when both requests are asserted with round-robin=0, grant the bit1-selected path.
REQ-018 SHALL, when both requests are asserted with round-robin=1, grant the path opposite to the last owner, with passive as the post-reset default.
REQ-019 SHALL, in LAUNCH, assert exactly the owner's trigger for one cycle, increment o_grant_count (wrapping 0xFFFF->0x0000) and move to RUN.
REQ-020 SHALL, in RUN, wait for the owner's i_end_* pulse and then move to RELEASE; the non-owner's end pulse SHALL be ignored.
REQ-021 SHALL, in RELEASE, clear o_owner to 00, update the last owner, and return to IDLE; minimum request-to-request spacing is 4 cycles.
REQ-022 SHALL leave an already-granted transaction running to completion if enable is deasserted mid-transaction, and grant no new request.
REQ-023 SHALL treat an end pulse coincident with LAUNCH as ignored.
REQ-024 SHALL, on a bit3 clear coincident with a LAUNCH increment, clear the counter, with clear taking priority.
REQ-025 SHALL never assert both triggers in the same cycle.

Reset
REQ-026 SHALL, while ace_aresetn=0, immediately force the FSM to IDLE, o_owner=00, both triggers=0, o_grant_count=0, last owner=active (so round-robin favours passive first), watchdog counter and sticky flag=0, o_status_reg=0.
REQ-027 SHALL, on a reset asserted mid-RUN, abandon the grant without emitting any pulse.

Configuration
REQ-028 SHALL compile in the RUN-state watchdog when macro DEVIL_ARB_WATCHDOG_EN is defined: a 16-bit counter increments each RUN cycle and clears on entry to RUN; when it reaches WDT_CYCLES-1 without an owner end pulse, the FSM SHALL go to RELEASE and set status bit2.
REQ-029 SHALL, when DEVIL_ARB_WATCHDOG_EN is undefined, remove the watchdog logic, keep RUN until the end pulse, and tie status bit2 to 0.

Structure
REQ-030 SHALL place the FSM state encodings, owner encodings and control/status bit indices in shared package devil_pkg.
REQ-031 SHALL use one sub-module, devil_rr_picker, which is combinational and takes the two requests, the last owner and the control bits to produce the winner.

Verification
REQ-032 SHALL cover: i_req_passive=1 only, enable=1 -> o_trigger_passive_path pulses one cycle later, o_owner=01, and the counter reads 1 after LAUNCH.
REQ-033 SHALL cover: both requests asserted, round-robin=1, four back-to-back completions -> grants alternate passive, active, passive, active.
REQ-034 SHALL cover: both requests asserted, round-robin=0, bit1=1 -> active is granted every time and passive is starved.
REQ-035 SHALL cover: enable dropped during RUN, then i_end_active -> RELEASE, then IDLE with no new trigger.
REQ-036 SHALL cover: with DEVIL_ARB_WATCHDOG_EN defined and WDT_CYCLES=16, no end pulse -> RELEASE after 16 RUN cycles and status bit2=1.
REQ-037 SHALL cover: ace_aresetn pulsed low mid-RUN -> all outputs 0 within the same cycle and a passive-first grant after release.
